// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller: FSM states,
// opcode/funct constants, ALU operation codes and ALU B-operand selects.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam int ALU_OP_W = 3;
  localparam logic [ALU_OP_W-1:0] ALU_NOP = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b110;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// R-type function-field decoder: maps funct to an ALU operation code and
// flags whether the funct is one the controller supports.
module mips_alu_dec import mips_ctrl_pkg::*; (
  input  logic [5:0]          funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                legal
);

  always_comb begin
    alu_op = ALU_NOP;
    legal  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_XOR:  alu_op = ALU_XOR;
      FN_SLT:  alu_op = ALU_SLT;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with memory handshake and wait
// timeout. Define MIPS_CTRL_BNE_EN to decode bne (opcode 000101); otherwise it is illegal.
module mips_multicycle_ctrl import mips_ctrl_pkg::*; #(
  parameter int ALUCTR_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          OprCtr,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWr,
  output logic                IRWr,
  output logic                MemRd,
  output logic                MemWr,
  output logic                IorD,
  output logic                RegDst,
  output logic                RegWr,
  output logic                ExtOp,
  output logic                ALUsrcA,
  output logic [1:0]          ALUsrcB,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic                MemtoReg,
  output logic                Branch,
  output logic                Jump,
  output logic                illegal,
  output logic                bus_err
);

  localparam bit                  TO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(MEM_TIMEOUT - 1);

  function automatic logic [ALUCTR_W-1:0] alu_code(input logic [ALU_OP_W-1:0] op);
    return ALUCTR_W'(op);
  endfunction

  state_e              state_q, state_d;
  logic [5:0]          op_q, op_d;
  logic [5:0]          funct_q, funct_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  logic [ALU_OP_W-1:0] fn_alu_op;
  logic                fn_legal;
  logic                is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j;
  logic                op_legal;
  logic                waiting, timeout;

  mips_alu_dec u_alu_dec (
    .funct  (funct_q),
    .alu_op (fn_alu_op),
    .legal  (fn_legal)
  );

  always_comb begin
    is_r    = (op_q == OP_RTYPE);
    is_addi = (op_q == OP_ADDI);
    is_lw   = (op_q == OP_LW);
    is_sw   = (op_q == OP_SW);
    is_beq  = (op_q == OP_BEQ);
    is_j    = (op_q == OP_J);
`ifdef MIPS_CTRL_BNE_EN
    is_bne  = (op_q == OP_BNE);
`else
    is_bne  = 1'b0;
`endif
    op_legal = (is_r && fn_legal) || is_addi || is_lw || is_sw || is_beq || is_bne;
  end

  // A wait cycle is IF/MEM without mem_ready; the MEM_TIMEOUT-th one aborts.
  always_comb begin
    waiting = ((state_q == ST_IF) || (state_q == ST_MEM)) && !mem_ready;
    timeout = TO_EN && waiting && (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    cnt_d   = '0;
    case (state_q)
      ST_IF: begin
        if (mem_ready) begin
          op_d    = OprCtr;
          funct_d = funct;
          state_d = ST_ID;
        end
      end
      ST_ID:  state_d = op_legal ? ST_EX : ST_IF;
      ST_EX: begin
        if (is_mem_op(op_q))      state_d = ST_MEM;
        else if (is_r || is_addi) state_d = ST_WB;
        else                      state_d = ST_IF;
      end
      ST_MEM: begin
        if (mem_ready)    state_d = is_lw ? ST_WB : ST_IF;
        else if (timeout) state_d = ST_IF;
      end
      ST_WB:   state_d = ST_IF;
      default: state_d = ST_IF;
    endcase
    // Saturate so a disabled timeout never wraps the counter.
    if (waiting && !timeout && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IF;
      op_q    <= '0;
      funct_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    RegWr    = 1'b0;
    ExtOp    = 1'b0;
    ALUsrcA  = 1'b0;
    ALUsrcB  = SRCB_RT;
    ALUctr   = '0;
    MemtoReg = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IF: begin
          MemRd   = 1'b1;
          ALUsrcB = SRCB_FOUR;
          ALUctr  = alu_code(ALU_ADD);
          IRWr    = mem_ready;
          PCWr    = mem_ready;
          bus_err = timeout;
        end
        ST_ID: begin
          ALUsrcB = SRCB_IMM_S2;
          ExtOp   = 1'b1;
          ALUctr  = alu_code(ALU_ADD);
          Jump    = is_j;
          illegal = !op_legal && !is_j;
        end
        ST_EX: begin
          ALUsrcA = 1'b1;
          if (is_r) begin
            ALUsrcB = SRCB_RT;
            ALUctr  = alu_code(fn_alu_op);
          end else if (is_addi || is_lw || is_sw) begin
            ALUsrcB = SRCB_IMM;
            ExtOp   = 1'b1;
            ALUctr  = alu_code(ALU_ADD);
          end else begin
            ALUsrcB = SRCB_RT;
            ALUctr  = alu_code(ALU_SUB);
            Branch  = is_bne ? !zero : (is_beq && zero);
          end
        end
        ST_MEM: begin
          IorD    = 1'b1;
          MemRd   = is_lw;
          // An aborted store must not leave a write strobe on the bus.
          MemWr   = is_sw && !timeout;
          bus_err = timeout;
        end
        ST_WB: begin
          RegWr    = 1'b1;
          RegDst   = !is_r;
          MemtoReg = is_lw;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: an instruction-plan model checked every
// cycle, plus hand-computed spot checks. Honours MIPS_CTRL_BNE_EN like the design.
module tb_mips_multicycle_ctrl;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst, zero, mem_ready;
  logic [5:0] OprCtr, funct;
  logic       PCWr, IRWr, MemRd, MemWr, IorD, RegDst, RegWr, ExtOp, ALUsrcA;
  logic [1:0] ALUsrcB;
  logic [2:0] ALUctr;
  logic       MemtoReg, Branch, Jump, illegal, bus_err;

  int n_chk  = 0;
  int n_fail = 0;

  mips_multicycle_ctrl #(.ALUCTR_W(3), .MEM_TIMEOUT(TO), .TO_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .OprCtr(OprCtr), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .MemRd(MemRd), .MemWr(MemWr),
    .IorD(IorD), .RegDst(RegDst), .RegWr(RegWr), .ExtOp(ExtOp), .ALUsrcA(ALUsrcA),
    .ALUsrcB(ALUsrcB), .ALUctr(ALUctr), .MemtoReg(MemtoReg), .Branch(Branch),
    .Jump(Jump), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef enum int {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_ILL} kind_t;
  typedef enum int {PH_IF, PH_ID, PH_EX, PH_MEM, PH_WB} phase_t;

  phase_t m_phase = PH_IF;
  phase_t m_plan[$];
  kind_t  m_kind  = K_ILL;
  int     m_alu   = 0;
  int     m_wait  = 0;

  function automatic int alu_of(input logic [5:0] fn);
    case (fn)
      6'h20: return 1;
      6'h22: return 2;
      6'h24: return 3;
      6'h25: return 4;
      6'h26: return 5;
      6'h2A: return 6;
      default: return -1;
    endcase
  endfunction

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (alu_of(fn) >= 0) ? K_R : K_ILL;
      6'h08: return K_ADDI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
`ifdef MIPS_CTRL_BNE_EN
      6'h05: return K_BNE;
`endif
      6'h02: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic bit to_hit();
    return (TO > 0) && !mem_ready && (m_wait == TO - 1);
  endfunction

  task automatic load_plan(input kind_t k);
    m_plan.delete();
    m_plan.push_back(PH_ID);
    if (k != K_J && k != K_ILL) m_plan.push_back(PH_EX);
    if (k == K_LW || k == K_SW) m_plan.push_back(PH_MEM);
    if (k == K_LW || k == K_R || k == K_ADDI) m_plan.push_back(PH_WB);
  endtask

  task automatic advance();
    m_wait = 0;
    if (m_plan.size() == 0) m_phase = PH_IF;
    else m_phase = m_plan.pop_front();
  endtask

  always @(posedge clk) begin : model
    bit hit;
    hit = to_hit();
    if (rst) begin
      m_phase = PH_IF;
      m_plan.delete();
      m_wait  = 0;
    end else begin
      case (m_phase)
        PH_IF: begin
          if (mem_ready) begin
            m_kind = classify(OprCtr, funct);
            m_alu  = alu_of(funct);
            load_plan(m_kind);
            advance();
          end else if (hit) m_wait = 0;
          else m_wait++;
        end
        PH_MEM: begin
          if (mem_ready) advance();
          else if (hit) begin
            m_plan.delete();
            m_phase = PH_IF;
            m_wait  = 0;
          end else m_wait++;
        end
        default: advance();
      endcase
    end
  end

  function automatic logic [18:0] model_out();
    logic pcwr, irwr, memrd, memwr, iord, regdst, regwr, extop, srca;
    logic memtoreg, branch, jump, ill, berr;
    logic [1:0] srcb;
    logic [2:0] ctr;
    {pcwr, irwr, memrd, memwr, iord, regdst, regwr, extop, srca} = '0;
    {memtoreg, branch, jump, ill, berr} = '0;
    srcb = 2'd0;
    ctr  = 3'd0;
    if (!rst) begin
      case (m_phase)
        PH_IF: begin
          memrd = 1; srcb = 2'd1; ctr = 3'd1;
          irwr = mem_ready; pcwr = mem_ready; berr = to_hit();
        end
        PH_ID: begin
          srcb = 2'd3; extop = 1; ctr = 3'd1;
          jump = (m_kind == K_J); ill = (m_kind == K_ILL);
        end
        PH_EX: begin
          srca = 1;
          if (m_kind == K_R) ctr = 3'(m_alu);
          else if (m_kind == K_BEQ || m_kind == K_BNE) begin
            ctr = 3'd2;
            branch = (m_kind == K_BEQ) ? zero : !zero;
          end else begin
            srcb = 2'd2; extop = 1; ctr = 3'd1;
          end
        end
        PH_MEM: begin
          iord = 1; berr = to_hit();
          memrd = (m_kind == K_LW);
          memwr = (m_kind == K_SW) && !to_hit();
        end
        PH_WB: begin
          regwr = 1; regdst = (m_kind != K_R); memtoreg = (m_kind == K_LW);
        end
        default: ;
      endcase
    end
    return {pcwr, irwr, memrd, memwr, iord, regdst, regwr, extop, srca, srcb, ctr,
            memtoreg, branch, jump, ill, berr};
  endfunction

  logic [18:0] dut_vec;
  assign dut_vec = {PCWr, IRWr, MemRd, MemWr, IorD, RegDst, RegWr, ExtOp, ALUsrcA,
                    ALUsrcB, ALUctr, MemtoReg, Branch, Jump, illegal, bus_err};

  always @(negedge clk) begin : compare
    logic [18:0] exp_vec;
    exp_vec = model_out();
    n_chk++;
    if (dut_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL outputs t=%0t phase=%0d: got %b, want %b", $time, m_phase, dut_vec, exp_vec);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // One clock cycle of inputs, applied just after the rising edge; returns mid-cycle.
  task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; OprCtr = op; funct = fn; zero = z; mem_ready = rdy;
    #4;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not end, want end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; OprCtr = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    cyc(1, 6'h00, 6'h20, 0, 1);
    cyc(1, 6'h00, 6'h20, 0, 1);
    chk("rst_memrd", MemRd, 0);
    chk("rst_irwr", IRWr, 0);

    // add: IF ID EX WB, next fetch on cycle 5
    cyc(0, 6'h00, 6'h20, 0, 1); chk("add_if_irwr", IRWr, 1); chk("add_if_srcb", ALUsrcB, 1);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("add_id_srcb", ALUsrcB, 3);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("add_ex_ctr", ALUctr, 1); chk("add_ex_srca", ALUsrcA, 1);
    chk("add_ex_srcb", ALUsrcB, 0);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("add_wb_regwr", RegWr, 1); chk("add_wb_regdst", RegDst, 0);

    // lw with three MEM waits: 8 cycles total
    cyc(0, 6'h23, 6'h00, 0, 1); chk("add_next_if", IRWr, 1);
    cyc(0, 6'h00, 6'h00, 0, 1);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("lw_ex_srcb", ALUsrcB, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 6'h00, 6'h00, 0, 0); chk("lw_mem_rd", MemRd, 1); chk("lw_mem_iord", IorD, 1);
    end
    cyc(0, 6'h00, 6'h00, 0, 1); chk("lw_mem_ready_iord", IorD, 1);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("lw_wb_m2r", MemtoReg, 1); chk("lw_wb_regdst", RegDst, 1);

    // beq taken then not taken
    cyc(0, 6'h04, 6'h00, 0, 1); chk("lw_next_if", IRWr, 1);
    cyc(0, 6'h00, 6'h00, 0, 1);
    cyc(0, 6'h00, 6'h00, 1, 1); chk("beq_z1_branch", Branch, 1); chk("beq_ctr", ALUctr, 2);
    cyc(0, 6'h04, 6'h00, 0, 1); chk("beq_next_if", IRWr, 1);
    cyc(0, 6'h00, 6'h00, 0, 1);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("beq_z0_branch", Branch, 0); chk("beq_regwr", RegWr, 0);

    // j, then illegal opcode, then sub, then illegal funct
    cyc(0, 6'h02, 6'h00, 0, 1);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("j_jump", Jump, 1);
    cyc(0, 6'h3F, 6'h00, 0, 1); chk("j_back_if", IRWr, 1);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("ill_pulse", illegal, 1); chk("ill_regwr", RegWr, 0);
    cyc(0, 6'h00, 6'h22, 0, 1); chk("ill_gone", illegal, 0);
    cyc(0, 6'h00, 6'h00, 0, 1);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("sub_ex_ctr", ALUctr, 2);
    cyc(0, 6'h00, 6'h00, 0, 1);
    cyc(0, 6'h00, 6'h21, 0, 1);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("badfn_illegal", illegal, 1);

    // IF timeout on the 15th wait, then mem_ready on a would-be timeout cycle
    for (int i = 1; i <= TO; i++) begin
      cyc(0, 6'h08, 6'h00, 0, 0);
      chk("to_if_irwr", IRWr, 0);
      chk("to_if_buserr", bus_err, (i == 15) ? 1 : 0);
    end
    for (int i = 1; i < TO; i++) cyc(0, 6'h08, 6'h00, 0, 0);
    chk("to_wait14_buserr", bus_err, 0);
    cyc(0, 6'h08, 6'h00, 0, 1); chk("ready_wins_buserr", bus_err, 0); chk("ready_wins_irwr", IRWr, 1);
    cyc(0, 6'h00, 6'h00, 0, 1);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("addi_ex_extop", ExtOp, 1);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("addi_wb_regdst", RegDst, 1); chk("addi_wb_m2r", MemtoReg, 0);

    // lw timing out in MEM
    cyc(0, 6'h23, 6'h00, 0, 1);
    cyc(0, 6'h00, 6'h00, 0, 1);
    cyc(0, 6'h00, 6'h00, 0, 1);
    for (int i = 1; i <= TO; i++) cyc(0, 6'h00, 6'h00, 0, 0);
    chk("mem_to_buserr", bus_err, 1);
    cyc(0, 6'h2B, 6'h00, 0, 1); chk("mem_to_back_if", IorD, 0); chk("mem_to_no_regwr", RegWr, 0);

    // sw aborted by reset in MEM, then a normal sw
    cyc(0, 6'h00, 6'h00, 0, 1);
    cyc(0, 6'h00, 6'h00, 0, 1);
    cyc(1, 6'h00, 6'h00, 0, 1); chk("rst_mem_memwr", MemWr, 0);
    cyc(0, 6'h2B, 6'h00, 0, 1); chk("rst_after_iord", IorD, 0); chk("rst_after_memrd", MemRd, 1);
    cyc(0, 6'h00, 6'h00, 0, 1);
    cyc(0, 6'h00, 6'h00, 0, 1);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("sw_mem_memwr", MemWr, 1);
    cyc(0, 6'h05, 6'h00, 0, 1); chk("sw_next_if", IRWr, 1);

    // bne with zero=0
    cyc(0, 6'h00, 6'h00, 0, 1);
`ifdef MIPS_CTRL_BNE_EN
    chk("bne_id_legal", illegal, 0);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("bne_branch", Branch, 1);
`else
    chk("bne_illegal", illegal, 1);
    cyc(0, 6'h00, 6'h00, 0, 1); chk("bne_back_if", MemRd, 1);
`endif
    cyc(0, 6'h00, 6'h20, 0, 1);

    @(posedge clk);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
